// File: rtl/ascon_pkg.sv
// Shared types, round constants and helpers for the Ascon permutation core.
package ascon_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned RND_W   = 5;
  localparam int unsigned MAX_RND = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RND_W-1:0]  rnd_t;

  // x0 occupies the most significant 64 bits.
  typedef struct packed {
    word_t x0;
    word_t x1;
    word_t x2;
    word_t x3;
    word_t x4;
  } ascon_state_t;

  // c[i] = {4'hf - m, m}, m = (i - 4) mod 16; entry 0 in the low byte.
  localparam logic [16*8-1:0] RC_LUT = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96, 8'ha5, 8'hb4,
    8'hc3, 8'hd2, 8'he1, 8'hf0, 8'h0f, 8'h1e, 8'h2d, 8'h3c
  };

  // Linear-layer right-rotation amounts.
  localparam int unsigned ROT_X0_A = 19;
  localparam int unsigned ROT_X0_B = 28;
  localparam int unsigned ROT_X1_A = 61;
  localparam int unsigned ROT_X1_B = 39;
  localparam int unsigned ROT_X2_A = 1;
  localparam int unsigned ROT_X2_B = 6;
  localparam int unsigned ROT_X3_A = 10;
  localparam int unsigned ROT_X3_B = 17;
  localparam int unsigned ROT_X4_A = 7;
  localparam int unsigned ROT_X4_B = 41;

  // Round constant lookup.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return RC_LUT[{idx, 3'b000} +: 8];
  endfunction

  // 64-bit rotate right by a constant amount (1..63).
  function automatic word_t ror64(input word_t v, input int unsigned r);
    return (v >> r) | (v << (WORD_W - r));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [7:0]   const_i,
  input  logic         en_i,
  output ascon_state_t state_o
);

  word_t a0, a1, a2, a3, a4;
  word_t b0, b2, b4;
  word_t c0, c1, c2, c3, c4;
  word_t d0, d1, d2, d3, d4;
  ascon_state_t lin;

  // Round datapath; a disabled stage forwards its input untouched.
  always_comb begin
    // constant addition into the low byte of x2
    a0 = state_i.x0;
    a1 = state_i.x1;
    a2 = {state_i.x2[WORD_W-1:8], state_i.x2[7:0] ^ const_i};
    a3 = state_i.x3;
    a4 = state_i.x4;

    // bit-sliced 5-bit S-box over all 64 columns
    b0 = a0 ^ a4;
    b4 = a4 ^ a3;
    b2 = a2 ^ a1;
    c0 = b0 ^ (~a1 & b2);
    c1 = a1 ^ (~b2 & a3);
    c2 = b2 ^ (~a3 & b4);
    c3 = a3 ^ (~b4 & b0);
    c4 = b4 ^ (~b0 & a1);
    d0 = c0 ^ c4;
    d1 = c1 ^ c0;
    d2 = ~c2;
    d3 = c3 ^ c2;
    d4 = c4;

    // linear diffusion per word
    lin.x0 = d0 ^ ror64(d0, ROT_X0_A) ^ ror64(d0, ROT_X0_B);
    lin.x1 = d1 ^ ror64(d1, ROT_X1_A) ^ ror64(d1, ROT_X1_B);
    lin.x2 = d2 ^ ror64(d2, ROT_X2_A) ^ ror64(d2, ROT_X2_B);
    lin.x3 = d3 ^ ror64(d3, ROT_X3_A) ^ ror64(d3, ROT_X3_B);
    lin.x4 = d4 ^ ror64(d4, ROT_X4_A) ^ ror64(d4, ROT_X4_B);

    state_o = en_i ? lin : state_i;
  end

endmodule

// File: rtl/ascon_permutation_core.sv
// Handshaked multi-cycle Ascon-p[rnd] engine with UNROLL rounds per cycle.
module ascon_permutation_core
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_valid_i,
  output logic         start_ready_o,
  input  rnd_t         num_rounds_i,
  input  ascon_state_t state_i,
  output logic         done_valid_o,
  input  logic         done_ready_i,
  output ascon_state_t state_o,
  output logic         busy_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6)) begin : g_bad_unroll
    $error("ascon_permutation_core: illegal UNROLL=%0d", UNROLL);
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam rnd_t UNROLL_R = rnd_t'(UNROLL);
  localparam rnd_t MAX_R    = rnd_t'(MAX_RND);

  logic [1:0]   st_q, st_d;
  ascon_state_t state_q, state_d;
  rnd_t         rem_q, rem_d;
  rnd_t         idx_q, idx_d;
  rnd_t         rnd_eff;
  rnd_t         step;

  ascon_state_t chain [UNROLL+1];

  // 0 and anything above 16 run the full 16 rounds.
  assign rnd_eff = ((num_rounds_i == '0) || (num_rounds_i > MAX_R)) ? MAX_R : num_rounds_i;

  // Rounds retired this cycle: min(UNROLL, rem).
  assign step = (rem_q > UNROLL_R) ? UNROLL_R : rem_q;

  // Unrolled round chain; stages past the remaining count are bypassed.
  assign chain[0] = state_q;
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    logic [3:0] cidx;
    assign cidx = 4'(idx_q + rnd_t'(j));
    ascon_round u_round (
      .state_i (chain[j]),
      .const_i (round_const(cidx)),
      .en_i    (rem_q > rnd_t'(j)),
      .state_o (chain[j+1])
    );
  end

  // Next-state, counter and handshake logic.
  always_comb begin
    st_d          = st_q;
    state_d       = state_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    start_ready_o = 1'b0;
    case (st_q)
      ST_IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          state_d = state_i;
          rem_d   = rnd_eff;
          idx_d   = MAX_R - rnd_eff;
          st_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = chain[UNROLL];
        rem_d   = rem_q - step;
        idx_d   = idx_q + step;
        if (rem_d == '0) begin
          st_d = ST_DONE;
        end
      end
      ST_DONE: begin
        start_ready_o = done_ready_i;
        if (done_ready_i) begin
          if (start_valid_i) begin
            state_d = state_i;
            rem_d   = rnd_eff;
            idx_d   = MAX_R - rnd_eff;
            st_d    = ST_RUN;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // State register, counters and FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  assign state_o      = state_q;
  assign done_valid_o = (st_q == ST_DONE);
  assign busy_o       = (st_q == ST_RUN);

endmodule
